mc_controller: RTL and testbench

Multicycle control unit for the RISC-V core: a Moore FSM that sequences one shared ALU, one unified instruction/data memory and the register file over several cycles per instruction. It sits beside the multicycle datapath, decodes the latched instruction fields, drives every mux select and write enable, and reports instruction completion. It supports lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/mc_pkg.sv | 76 +++++++
 rtl/mc_aludec.sv | 35 +++
 rtl/mc_mainfsm.sv | 153 +++++++++++++++
 rtl/mc_controller.sv | 75 +++++++
 tb/tb_mc_controller.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
// FSM state enum, datapath mux select codes, ALUOp / ALUControl codes,
// supported opcodes and the immediate-format decode helper.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } statetype_t;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp encodings (main FSM to aludec)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Supported opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // Immediate format for an opcode; unknown opcodes fall back to I-type
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// aludec: ALU operation decode from ALUOp and the instruction fields.
// op5 separates R-type sub from I-type addi (instr[30] is part of the
// immediate for addi); funct7b5 separates sra/srai from srl/srli.
module aludec
  import mc_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] ALUControl
);

  // Select the ALU operation; fixed add/sub unless the FSM asks for funct decode
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_mainfsm.sv
// mainfsm: state register, next-state logic and per-state Moore outputs
// of the multicycle controller.
// Optional MC_MEMREADY_EN: adds MemReady; FETCH, MEMREAD and MEMWRITE then
// hold until memory accepts. Without it those states take one cycle.
module mainfsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
`ifdef MC_MEMREADY_EN
  input  logic       MemReady,
`endif
  output statetype_t state,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal
);

  statetype_t state_reg;
  statetype_t state_next;
  logic       mem_ready;

`ifdef MC_MEMREADY_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign state = state_reg;

  // State register; reset always restarts at an instruction fetch
  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  // Next state and per-state outputs; reset suppresses every enable
  always_comb begin
    state_next = FETCH;
    Branch     = 1'b0;
    PCUpdate   = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    RegWrite   = 1'b0;
    ALUOp      = ALUOP_ADD;
    InstrDone  = 1'b0;
    Illegal    = 1'b0;
    case (state_reg)
      FETCH: begin
        // op is not valid yet here, so nothing below looks at it
        IRWrite    = mem_ready;
        PCUpdate   = mem_ready;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch/jump target OldPC + imm
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_ITYPE:          state_next = EXECUTEI;
          OP_BRANCH:         state_next = BEQ;
          OP_JAL:            state_next = JAL;
          default: begin
            state_next = FETCH;
            Illegal    = 1'b1;
            InstrDone  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // write strobe stays up while memory stalls; done only on accept
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        InstrDone  = mem_ready;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        Branch     = 1'b1;
        InstrDone  = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // PC takes the target held in ALUOut; ALU forms the link OldPC + 4
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCUpdate   = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
    if (reset) begin
      Branch    = 1'b0;
      PCUpdate  = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control unit (lw, sw, R, I, beq, jal).
// Combines the main FSM, the ALU decoder, the immediate-format decode and
// the PC write enable. All outputs are combinational; none are registered.
// Optional MC_MEMREADY_EN: adds the MemReady input for stalling memory.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
`ifdef MC_MEMREADY_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       InstrDone,
  output logic       Illegal
);

  statetype_t state;
  logic       branch;
  logic       pc_update;
  logic [1:0] alu_op;

  mainfsm u_mainfsm (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
`ifdef MC_MEMREADY_EN
    .MemReady  (MemReady),
`endif
    .state     (state),
    .Branch    (branch),
    .PCUpdate  (pc_update),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .RegWrite  (RegWrite),
    .ALUOp     (alu_op),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  aludec u_aludec (
    .ALUOp      (alu_op),
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

  // Immediate format from the opcode; held at I-type in FETCH where op is stale
  always_comb begin
    ImmSrc = IMM_I;
    if (state != FETCH) ImmSrc = imm_sel(op);
  end

  // Branch and PCUpdate are already cleared by the FSM during reset
  assign PCWrite = (branch & Zero) | pc_update;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vector table, hand-written reset/stall sequences
// and randomized instruction streams checked against a per-instruction model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
`ifdef MC_MEMREADY_EN
  logic       MemReady;
`endif
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
`ifdef MC_MEMREADY_EN
    .MemReady   (MemReady),
`endif
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .InstrDone  (InstrDone),
    .Illegal    (Illegal)
  );

  typedef struct packed {
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       InstrDone;
    logic       Illegal;
  } outs_t;

  outs_t got;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, InstrDone, Illegal};

  typedef enum {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB, PH_MEMWRITE,
                PH_EXECR, PH_EXECI, PH_ALUWB, PH_BEQ, PH_JAL} phase_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
    logic [2:0] imm;
    bit         chk3;
    logic [3:0] alu3;
    logic       pcw3;
  } vec_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic bit supported(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JL);
  endfunction

  // ALU operation the datapath must perform for a given ALUOp and fields
  function automatic logic [3:0] alu_ref(input logic [1:0] aluop, input logic o5,
                                         input logic [2:0] f3, input logic f7);
    if (aluop == 2'b00) return 4'b0000;
    if (aluop == 2'b01) return 4'b0001;
    case (f3)
      3'd0: return (o5 && f7) ? 4'b0001 : 4'b0000;
      3'd1: return 4'b0110;
      3'd2: return 4'b0101;
      3'd3: return 4'b0111;
      3'd4: return 4'b0100;
      3'd5: return f7 ? 4'b1001 : 4'b1000;
      3'd6: return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    if (o == SW) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JL) return 3'b011;
    return 3'b000;
  endfunction

  // Expected outputs for one cycle of an instruction, from the per-step table
  function automatic outs_t model(input phase_t ph, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z);
    outs_t e;
    logic [1:0] aluop;
    logic br, pcu;
    e = '0; aluop = 2'b00; br = 1'b0; pcu = 1'b0;
    case (ph)
      PH_FETCH:    begin e.IRWrite = 1; e.ALUSrcB = 2'b10; e.ResultSrc = 2'b10; pcu = 1; end
      PH_DECODE:   begin
        e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01;
        if (!supported(o)) begin e.Illegal = 1; e.InstrDone = 1; end
      end
      PH_MEMADR:   begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; end
      PH_MEMREAD:  e.AdrSrc = 1;
      PH_MEMWB:    begin e.ResultSrc = 2'b01; e.RegWrite = 1; e.InstrDone = 1; end
      PH_MEMWRITE: begin e.AdrSrc = 1; e.MemWrite = 1; e.InstrDone = 1; end
      PH_EXECR:    begin e.ALUSrcA = 2'b10; aluop = 2'b10; end
      PH_EXECI:    begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; aluop = 2'b10; end
      PH_ALUWB:    begin e.RegWrite = 1; e.InstrDone = 1; end
      PH_BEQ:      begin e.ALUSrcA = 2'b10; aluop = 2'b01; br = 1; e.InstrDone = 1; end
      default:     begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; pcu = 1; end
    endcase
    e.PCWrite    = (br & z) | pcu;
    e.ALUControl = alu_ref(aluop, o[5], f3, f7);
    e.ImmSrc     = (ph == PH_FETCH) ? 3'b000 : imm_ref(o);
    return e;
  endfunction

  // Steps after FETCH/DECODE for each instruction kind
  task automatic plan(input logic [6:0] o, output int n, output phase_t t[3]);
    t = '{PH_FETCH, PH_FETCH, PH_FETCH};
    case (o)
      LW:      begin n = 5; t = '{PH_MEMADR, PH_MEMREAD, PH_MEMWB}; end
      SW:      begin n = 4; t = '{PH_MEMADR, PH_MEMWRITE, PH_FETCH}; end
      RT:      begin n = 4; t = '{PH_EXECR, PH_ALUWB, PH_FETCH}; end
      IT:      begin n = 4; t = '{PH_EXECI, PH_ALUWB, PH_FETCH}; end
      BR:      begin n = 3; t = '{PH_BEQ, PH_FETCH, PH_FETCH}; end
      JL:      begin n = 4; t = '{PH_JAL, PH_ALUWB, PH_FETCH}; end
      default: n = 2;
    endcase
  endtask

  // One clock of stimulus, sampled on the falling edge and compared to the model
  task automatic step(input phase_t ph, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, output outs_t obs);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
`ifdef MC_MEMREADY_EN
    MemReady = 1'b1;
`endif
    @(negedge clk);
    obs = got;
    check($sformatf("%s op=%b", ph.name(), o), 32'(got), 32'(model(ph, o, f3, f7, z)));
    @(posedge clk); #1;
  endtask

  // Whole instruction; the FETCH cycle sees junk fields since the IR is not loaded yet
  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, output int lat, output logic [2:0] imm_d,
                          output logic [3:0] alu3, output logic pcw3);
    int n;
    phase_t t[3];
    phase_t ph;
    outs_t obs;
    plan(o, n, t);
    lat = 0; imm_d = '0; alu3 = '0; pcw3 = 1'b0;
    for (int k = 0; k < n; k++) begin
      ph = (k == 0) ? PH_FETCH : (k == 1) ? PH_DECODE : t[k-2];
      if (k == 0) step(ph, 7'($urandom), 3'($urandom), 1'($urandom), z, obs);
      else        step(ph, o, f3, f7, z, obs);
      if (obs.InstrDone && lat == 0) lat = k + 1;
      if (k == 1) imm_d = obs.ImmSrc;
      if (k == 2) begin alu3 = obs.ALUControl; pcw3 = obs.PCWrite; end
    end
    $display("instr op=%b f3=%b f7=%b z=%b done_at=%0d", o, f3, f7, z, lat);
  endtask

  task automatic check_enables_off(input string name);
    @(negedge clk);
    check(name, 32'({PCWrite, IRWrite, MemWrite, RegWrite, InstrDone, Illegal}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    outs_t obs;
    int lat;
    logic [2:0] imm_d;
    logic [3:0] alu3;
    logic pcw3;
    logic [6:0] o;

    //            op  f3    f7 z  lat imm    chk3 alu3     pcw3
    tbl[0]  = '{LW, 3'd2, 0, 0, 5, 3'b000, 1, 4'b0000, 0};
    tbl[1]  = '{SW, 3'd2, 0, 1, 4, 3'b001, 1, 4'b0000, 0};
    tbl[2]  = '{RT, 3'd0, 1, 1, 4, 3'b000, 1, 4'b0001, 0};
    tbl[3]  = '{RT, 3'd0, 0, 0, 4, 3'b000, 1, 4'b0000, 0};
    tbl[4]  = '{RT, 3'd6, 0, 0, 4, 3'b000, 1, 4'b0011, 0};
    tbl[5]  = '{IT, 3'd0, 1, 0, 4, 3'b000, 1, 4'b0000, 0};
    tbl[6]  = '{IT, 3'd7, 0, 1, 4, 3'b000, 1, 4'b0010, 0};
    tbl[7]  = '{BR, 3'd0, 0, 1, 3, 3'b010, 1, 4'b0001, 1};
    tbl[8]  = '{BR, 3'd0, 0, 0, 3, 3'b010, 1, 4'b0001, 0};
    tbl[9]  = '{JL, 3'd0, 0, 0, 4, 3'b011, 1, 4'b0000, 1};
    tbl[10] = '{7'b1111111, 3'd0, 0, 0, 2, 3'b000, 0, 4'b0000, 0};

    // Reset: all enables held low, state parked in FETCH
    reset = 1'b1; op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'b0; Zero = 1'b1;
`ifdef MC_MEMREADY_EN
    MemReady = 1'b1;
`endif
    check_enables_off("reset_enables_a");
    check_enables_off("reset_enables_b");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      do_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, lat, imm_d, alu3, pcw3);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d_immsrc", i), 32'(imm_d), 32'(tbl[i].imm));
      if (tbl[i].chk3) begin
        check($sformatf("vec%0d_alucontrol_c3", i), 32'(alu3), 32'(tbl[i].alu3));
        check($sformatf("vec%0d_pcwrite_c3", i), 32'(pcw3), 32'(tbl[i].pcw3));
      end
    end

    // Reset during MEMADR of a lw aborts it and restarts at FETCH
    step(PH_FETCH, 7'($urandom), 3'd0, 1'b0, 1'b0, obs);
    step(PH_DECODE, LW, 3'd2, 1'b0, 1'b0, obs);
    reset = 1'b1;
    check_enables_off("reset_in_memadr");
    @(posedge clk); #1;
    reset = 1'b0;
    step(PH_FETCH, 7'($urandom), 3'd0, 1'b0, 1'b0, obs);
    $display("seq lw aborted by reset in MEMADR");

    // Reset during MEMWRITE of a sw must suppress the write strobe
    step(PH_DECODE, SW, 3'd2, 1'b0, 1'b0, obs);
    step(PH_MEMADR, SW, 3'd2, 1'b0, 1'b0, obs);
    reset = 1'b1;
    check_enables_off("reset_in_memwrite");
    @(posedge clk); #1;
    reset = 1'b0;
    do_instr(BR, 3'd0, 1'b0, 1'b1, lat, imm_d, alu3, pcw3);
    check("post_reset_beq_latency", 32'(lat), 32'd3);
    $display("seq sw aborted by reset in MEMWRITE");

`ifdef MC_MEMREADY_EN
    // Stalled FETCH, then sw whose MEMWRITE is held for three cycles
    MemReady = 1'b0; op = 7'($urandom);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("fetch_hold_irw_pcw", 32'({IRWrite, PCWrite}), 32'd0);
      @(posedge clk); #1;
    end
    MemReady = 1'b1;
    @(negedge clk);
    check("fetch_accept_irw_pcw", 32'({IRWrite, PCWrite}), 32'b11);
    @(posedge clk); #1;
    step(PH_DECODE, SW, 3'd2, 1'b0, 1'b0, obs);
    step(PH_MEMADR, SW, 3'd2, 1'b0, 1'b0, obs);
    MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("memwrite_hold_mw_done", 32'({MemWrite, InstrDone}), 32'b10);
      @(posedge clk); #1;
    end
    MemReady = 1'b1;
    @(negedge clk);
    check("memwrite_accept_mw_done", 32'({MemWrite, InstrDone}), 32'b11);
    @(posedge clk); #1;
    step(PH_FETCH, 7'($urandom), 3'd0, 1'b0, 1'b0, obs);
    $display("seq sw with MemReady stall");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(6, 0))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JL;
        default: begin
          o = 7'($urandom);
          while (supported(o)) o = 7'($urandom);
        end
      endcase
      do_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), lat, imm_d, alu3, pcw3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
